mem_write_buffer: RTL and testbench
===================================

MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered word writes; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_b  input  1  asynchronous active-low reset.
REQ-004 up_addr  input  32  byte address from cache side.
REQ-005 up_wdata  input  8 x [0:3]  write bytes; index 0 = bits 31:24.
REQ-006 up_we  input  1  cache-side write request.
REQ-007 up_re  input  1  cache-side read request.
REQ-008 up_ready  output  1  write accepted this cycle / read data valid this cycle.
REQ-009 up_rdata  output  8 x [0:3]  read data to cache; same byte order as up_wdata.
REQ-010 flush  input  1  drain all entries before accepting more traffic.
REQ-011 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-012 buf_empty  output  1  high when count == 0.
REQ-013 mem_addr  output  32  memory byte address.
REQ-014 mem_data_in  output  8 x [0:3]  write bytes to memory.
REQ-015 mem_write_en  output  1  memory write strobe.
REQ-016 mem_data_out  input  8 x [0:3]  combinational read data from memory.

Function
REQ-017 Storage: circular FIFO of DEPTH entries {addr[31:0], data[4x8]}; head, tail, count registers; pointers wrap modulo DEPTH; no coalescing of same-address writes.
REQ-018 FSM states RUN, FLUSH; RUN -> FLUSH on flush=1; FLUSH -> RUN on the posedge where count goes 1 -> 0, or immediately if count == 0.
REQ-019 flush_done = 1 for exactly the cycle after FLUSH -> RUN; flush held high after completion re-enters FLUSH and completes in one cycle when empty.
REQ-020 RUN write: up_we=1 and count < DEPTH -> up_ready=1, entry enqueued at tail on posedge; count == DEPTH -> up_ready=0, nothing enqueued; full is evaluated on the registered count, so a same-cycle drain does not free a slot for that cycle.
REQ-021 up_we=1 and up_re=1 together: treated as a write only; up_re ignored.
REQ-022 Drain: count > 0 and no read in progress (up_re=0 or state FLUSH) -> mem_write_en=1, mem_addr/mem_data_in = head entry, head advances on posedge; one entry per cycle.
REQ-023 RUN read, no buffered match: mem_write_en=0, mem_addr=up_addr, up_rdata=mem_data_out, up_ready=1, drain paused that cycle.
REQ-024 Match = up_addr[31:2] equals a valid entry addr[31:2].
REQ-025 Enqueue and dequeue in the same cycle leave count unchanged.
REQ-026 FLUSH: up_ready=0 for all requests; draining has priority over reads.
REQ-027 Idle (no request, count == 0): mem_write_en=0, mem_addr=up_addr, up_rdata=mem_data_out.

Reset
REQ-028 While rst_b=0: head=tail=count=0, state RUN, flush_done=0, mem_write_en=0, buf_empty=1, up_ready=0.
REQ-029 Reset mid-drain or mid-flush discards all buffered entries; no partial write is issued after rst_b falls.

Configuration
REQ-030 Macro MEM_WRITE_BUFFER_FORWARD_EN defined: read with a buffered match returns the youngest matching entry's data, up_ready=1, memory not read, drain proceeds that cycle.
REQ-031 Macro undefined: read with a buffered match gives up_ready=0 and drains entries each cycle until no match remains; the read then completes from memory.

Verification
REQ-032 Reset, then 4 writes to 0x10,0x14,0x18,0x1C with up_re=0 -> mem_write_en high 4 consecutive cycles after the first enqueue, addresses in order, buf_empty=1 at end.
REQ-033 Hold up_re=1 to 0x100 while issuing 5 writes (DEPTH=4) -> 5th write sees up_ready=0; no mem_write_en while up_re=1.
REQ-034 Write 0xDEADBEEF to 0x20, read 0x22 next cycle with up_re held: FORWARD_EN -> up_rdata=DE AD BE EF same cycle; without it -> up_ready=0 one cycle, then data from memory = DEADBEEF.
REQ-035 Fill 3 entries, assert flush one cycle -> up_ready=0 for 3 cycles, 3 drains, flush_done pulse on cycle 4, buf_empty=1.
REQ-036 Fill 2 entries, drop rst_b during first drain -> mem_write_en=0 immediately, count=0 after release, no further writes.

Source files
------------

// File: rtl/mem_write_buffer.sv
// Posted write buffer between a cache and memory: a DEPTH-entry FIFO drained one word per cycle.
// Define MEM_WRITE_BUFFER_FORWARD_EN to let reads that hit a buffered entry return its data directly.
module mem_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [31:0]      up_addr,
   input  logic [0:3][7:0]  up_wdata,
   input  logic             up_we,
   input  logic             up_re,
   output logic             up_ready,
   output logic [0:3][7:0]  up_rdata,
   input  logic             flush,
   output logic             flush_done,
   output logic             buf_empty,
   output logic [31:0]      mem_addr,
   output logic [0:3][7:0]  mem_data_in,
   output logic             mem_write_en,
   input  logic [0:3][7:0]  mem_data_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;
   logic               r_flushDone;
   logic [31:0]        r_addrMem [DEPTH];
   logic [0:3][7:0]    r_dataMem [DEPTH];

   logic               w_isRun;
   logic               w_full;
   logic               w_wrReq;
   logic               w_rdReq;
   logic               w_enq;
   logic               w_deq;
   logic               w_match;
   logic [0:3][7:0]    w_fwdData;
   logic               w_flushComplete;
   logic [PTR_W-1:0]   w_idx;

   // Scan oldest to youngest so the last hit seen is the youngest matching entry.
   always_comb begin
      w_match   = 1'b0;
      w_fwdData = '0;
      w_idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PTR_W'(k);
         if ((CNT_W'(k) < r_count) && (r_addrMem[w_idx][31:2] == up_addr[31:2])) begin
            w_match   = 1'b1;
            w_fwdData = r_dataMem[w_idx];
         end
      end
   end

   // A raw up_re stalls draining in RUN, except when the read itself is waiting on a buffered hit.
   always_comb begin
      w_isRun = (r_state == RUN);
      w_full  = (r_count == CNT_W'(DEPTH));
      w_wrReq = rst_b && w_isRun && up_we;
      w_rdReq = rst_b && w_isRun && up_re && !up_we;
      w_enq   = w_wrReq && !w_full;
      w_deq   = rst_b && (r_count != '0) && (!up_re || !w_isRun || (w_rdReq && w_match));

      up_ready     = 1'b0;
      up_rdata     = mem_data_out;
      mem_write_en = w_deq;
      mem_addr     = w_deq ? r_addrMem[r_head] : up_addr;
      mem_data_in  = r_dataMem[r_head];

      if (w_enq)
         up_ready = 1'b1;
      if (w_rdReq && !w_match)
         up_ready = 1'b1;
`ifdef MEM_WRITE_BUFFER_FORWARD_EN
      if (w_rdReq && w_match) begin
         up_ready = 1'b1;
         up_rdata = w_fwdData;
      end
`endif
   end

   always_comb begin
      w_flushComplete = (r_state == FLUSH) &&
                        ((r_count == '0) || ((r_count == CNT_W'(1)) && w_deq));
      w_nextState = r_state;
      case (r_state)
         RUN:     if (flush) w_nextState = FLUSH;
         FLUSH:   if (w_flushComplete) w_nextState = RUN;
         default: w_nextState = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         r_state <= RUN;
      else
         r_state <= w_nextState;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_flushDone <= 1'b0;
      end else begin
         r_flushDone <= w_flushComplete;
         if (w_enq)
            r_tail <= r_tail + PTR_W'(1);
         if (w_deq)
            r_head <= r_head + PTR_W'(1);
         if (w_enq && !w_deq)
            r_count <= r_count + CNT_W'(1);
         else if (!w_enq && w_deq)
            r_count <= r_count - CNT_W'(1);
      end
   end

   // Entry payloads need no reset; validity is tracked solely by head and count.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addrMem[r_tail] <= up_addr;
         r_dataMem[r_tail] <= up_wdata;
      end
   end

   assign flush_done = r_flushDone;
   assign buf_empty  = (r_count == '0);

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer with a small word-addressed memory model behind it.
// Expectations switch on MEM_WRITE_BUFFER_FORWARD_EN where read-hit behaviour differs.
module tb_mem_write_buffer;

   logic             clk;
   logic             rst_b;
   logic [31:0]      up_addr;
   logic [0:3][7:0]  up_wdata;
   logic             up_we;
   logic             up_re;
   logic             up_ready;
   logic [0:3][7:0]  up_rdata;
   logic             flush;
   logic             flush_done;
   logic             buf_empty;
   logic [31:0]      mem_addr;
   logic [0:3][7:0]  mem_data_in;
   logic             mem_write_en;
   logic [0:3][7:0]  mem_data_out;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] tbMem [256] = '{default: 32'h0};

   mem_write_buffer #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .up_addr      (up_addr),
      .up_wdata     (up_wdata),
      .up_we        (up_we),
      .up_re        (up_re),
      .up_ready     (up_ready),
      .up_rdata     (up_rdata),
      .flush        (flush),
      .flush_done   (flush_done),
      .buf_empty    (buf_empty),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_write_en (mem_write_en),
      .mem_data_out (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns read data combinationally and commits strobed writes on the clock edge.
   assign mem_data_out = tbMem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_write_en)
         tbMem[mem_addr[9:2]] <= mem_data_in;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge and let combinational outputs settle.
   task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] data, input logic fl);
      @(negedge clk);
      up_we    = we;
      up_re    = re;
      up_addr  = addr;
      up_wdata = data;
      flush    = fl;
      #1;
   endtask

   task automatic waitEmpty();
      for (int n = 0; n < 20 && !buf_empty; n++)
         applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("drain_done", 32'(buf_empty), 32'd1);
   endtask

   initial begin
      rst_b    = 1'b0;
      up_we    = 1'b1;
      up_re    = 1'b0;
      up_addr  = 32'h10;
      up_wdata = 32'h11223344;
      flush    = 1'b0;
      #2;
      checkOutput("rst_ready", 32'(up_ready), 32'd0);
      checkOutput("rst_mwe", 32'(mem_write_en), 32'd0);
      checkOutput("rst_empty", 32'(buf_empty), 32'd1);
      checkOutput("rst_fdone", 32'(flush_done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      up_we = 1'b0;

      // Four back-to-back writes drain in order, one cycle behind each enqueue.
      applyStimulus(1'b1, 1'b0, 32'h10, 32'hA0A0A010, 1'b0);
      checkOutput("w0_ready", 32'(up_ready), 32'd1);
      checkOutput("w0_mwe", 32'(mem_write_en), 32'd0);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'hA0A0A010 + 32'(4 * i), 1'b0);
         checkOutput("wn_ready", 32'(up_ready), 32'd1);
         checkOutput("wn_mwe", 32'(mem_write_en), 32'd1);
         checkOutput("wn_maddr", mem_addr, 32'h10 + 32'(4 * (i - 1)));
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("w4_mwe", 32'(mem_write_en), 32'd1);
      checkOutput("w4_maddr", mem_addr, 32'h1C);
      checkOutput("w4_mdata", mem_data_in, 32'hA0A0A01C);
      applyStimulus(1'b0, 1'b0, 32'h14, 32'h0, 1'b0);
      checkOutput("idle_mwe", 32'(mem_write_en), 32'd0);
      checkOutput("idle_empty", 32'(buf_empty), 32'd1);
      checkOutput("idle_maddr", mem_addr, 32'h14);
      checkOutput("idle_rdata", up_rdata, 32'hA0A0A014);

      // Writes with up_re held: no draining, the fifth write finds the buffer full.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h100, 32'hC0DE0000 + 32'(i), 1'b0);
         checkOutput("full_ready", 32'(up_ready), 32'(i < 4));
         checkOutput("full_mwe", 32'(mem_write_en), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
      checkOutput("hit_mwe", 32'(mem_write_en), 32'd1);
      checkOutput("hit_maddr", mem_addr, 32'h100);
`ifdef MEM_WRITE_BUFFER_FORWARD_EN
      checkOutput("hit_ready", 32'(up_ready), 32'd1);
      checkOutput("hit_youngest", up_rdata, 32'hC0DE0003);
`else
      checkOutput("hit_ready", 32'(up_ready), 32'd0);
`endif
      waitEmpty();
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
      checkOutput("mem100_ready", 32'(up_ready), 32'd1);
      checkOutput("mem100_rdata", up_rdata, 32'hC0DE0003);
      checkOutput("mem100_mwe", 32'(mem_write_en), 32'd0);

      // Read-after-write to the same word on the next cycle.
      applyStimulus(1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
      checkOutput("raw_wready", 32'(up_ready), 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
      checkOutput("raw_mwe", 32'(mem_write_en), 32'd1);
      checkOutput("raw_maddr", mem_addr, 32'h20);
`ifdef MEM_WRITE_BUFFER_FORWARD_EN
      checkOutput("raw_ready", 32'(up_ready), 32'd1);
      checkOutput("raw_fwd", up_rdata, 32'hDEADBEEF);
`else
      checkOutput("raw_ready", 32'(up_ready), 32'd0);
`endif
      applyStimulus(1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
      checkOutput("raw2_ready", 32'(up_ready), 32'd1);
      checkOutput("raw2_rdata", up_rdata, 32'hDEADBEEF);
      checkOutput("raw2_mwe", 32'(mem_write_en), 32'd0);

      // Flush three buffered entries; the done pulse follows the last drain.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'h5A5A0000 + 32'(i), 1'b0);
         checkOutput("fill_ready", 32'(up_ready), 32'd1);
      end
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b1);
      checkOutput("fl_rd_ready", 32'(up_ready), 32'd1);
      checkOutput("fl_rd_mwe", 32'(mem_write_en), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h100, 32'h77, 1'b0);
         checkOutput("fl_ready", 32'(up_ready), 32'd0);
         checkOutput("fl_mwe", 32'(mem_write_en), 32'd1);
         checkOutput("fl_maddr", mem_addr, 32'h200 + 32'(4 * i));
         checkOutput("fl_fdone", 32'(flush_done), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("fl_done", 32'(flush_done), 32'd1);
      checkOutput("fl_empty", 32'(buf_empty), 32'd1);
      checkOutput("fl_idle_mwe", 32'(mem_write_en), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("fl_done_clr", 32'(flush_done), 32'd0);

      // Flushing an empty buffer completes after a single FLUSH cycle.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("efl_fdone0", 32'(flush_done), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h12345678, 1'b0);
      checkOutput("efl_ready", 32'(up_ready), 32'd0);
      checkOutput("efl_fdone1", 32'(flush_done), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("efl_fdone2", 32'(flush_done), 32'd1);

      // Reset during a drain discards everything without completing the write.
      applyStimulus(1'b1, 1'b1, 32'h300, 32'h33330000, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h304, 32'h33330004, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rd_mwe", 32'(mem_write_en), 32'd1);
      checkOutput("rd_maddr", mem_addr, 32'h300);
      #1;
      rst_b = 1'b0;
      #1;
      checkOutput("rd_rst_mwe", 32'(mem_write_en), 32'd0);
      checkOutput("rd_rst_empty", 32'(buf_empty), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
         checkOutput("post_mwe", 32'(mem_write_en), 32'd0);
         checkOutput("post_empty", 32'(buf_empty), 32'd1);
      end
      checkOutput("mem300", tbMem[8'hC0], 32'h0);
      checkOutput("mem304", tbMem[8'hC1], 32'h0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
